mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one memory port between instruction fetch (requester 0) and data access (requester 1). It grants ownership, sequences the per-beat valid/ready handshake with memory, and drives the `sel` input of the `busMux2_1` instances that steer address and write data onto the shared port. The data muxes sit outside this block; it owns only the control.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: control for one memory port shared by instruction fetch (req0) and data access (req1).
// Latency: grant one cycle after request; ack in the same cycle the beat completes.
// Backpressure: mem_ready stalls the owner's beat; one IDLE bubble separates consecutive owners.
// Build option ARB_ROUND_ROBIN_EN: round-robin ties plus forced release after MAX_BEATS beats.
// Without it, requester 1 wins ties and an owner keeps the port until it drops its request.
module mem_port_arbiter #(
    parameter int MAX_BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic ack0,
    output logic ack1,
    output logic sel,
    output logic mem_valid,
    input  logic mem_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic owner;
    logic owner_req;
    logic winner;
    logic next_owner;
    logic grant_edge;
    logic beat_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last;
    logic       other_req;
    logic [7:0] beat_cnt;
    logic       cnt_at_max;

    assign other_req  = owner ? req0 : req1;
    assign cnt_at_max = (beat_cnt == 8'(MAX_BEATS - 1));
`endif

    assign owner_req  = owner ? req1 : req0;
    assign grant_edge = (state == IDLE) && (req0 || req1);
    assign next_owner = (state == IDLE) ? winner : owner;

    // Tie-break between the two requesters when the port is free.
    always_comb begin
        winner = req1;
`ifdef ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            winner = ~last;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant on any request, release when the owner lets go or is forced out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                end
`ifdef ARB_ROUND_ROBIN_EN
                else if (beat_done && cnt_at_max && other_req) begin
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: beat handshake toward memory; suppressed during reset so an in-flight beat is dropped.
    always_comb begin
        mem_valid = (state == GRANT) && owner_req && !reset;
        beat_done = mem_valid && mem_ready;
        ack0      = beat_done && !owner;
        ack1      = beat_done && owner;
    end

    // Ownership, mux select and grant flops; only the IDLE->GRANT edge may change owner/sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= 1'b0;
            sel   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
        end else begin
            if (grant_edge) begin
                owner <= winner;
                sel   <= winner;
            end
            gnt0 <= (state_nxt == GRANT) && !next_owner;
            gnt1 <= (state_nxt == GRANT) && next_owner;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Most recent owner; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant_edge) begin
            last <= winner;
        end
    end

    // Beats completed in the current tenure; wraps when no competitor forces a release.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= 8'd0;
        end else if (grant_edge) begin
            beat_cnt <= 8'd0;
        end else if (beat_done) begin
            beat_cnt <= cnt_at_max ? 8'd0 : beat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an ack scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Covers both builds, selected by ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic ack0;
    logic ack1;
    logic sel;
    logic mem_valid;
    logic mem_ready;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_ack_q[$];
    logic [1:0] eg;
    logic       es;

    mem_port_arbiter #(.MAX_BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cyc();
        @(negedge clk);
    endtask

    // Expected ack code: 2'b01 for requester 0, 2'b10 for requester 1.
    task automatic push_ack(input logic id);
        exp_ack_q.push_back(id ? 2'b10 : 2'b01);
    endtask

    // Scoreboard: every ack seen must match the oldest expected ack.
    always @(negedge clk) begin
        logic [1:0] e;
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
            e = (exp_ack_q.size() != 0) ? exp_ack_q.pop_front() : 2'b00;
            chk("sb_ack", {6'd0, ack1, ack0}, {6'd0, e});
        end
    end

    initial begin
        reset     = 1'b1;
        req0      = 1'b1;
        req1      = 1'b1;
        mem_ready = 1'b0;

        // Reset held two cycles with both requests high.
        for (int r = 0; r < 2; r++) begin
            next_cyc();
            mid_cyc();
            chk("rst_gnt", {6'd0, gnt1, gnt0}, 8'h00);
            chk("rst_sel", {7'd0, sel}, 8'h00);
            chk("rst_mv",  {7'd0, mem_valid}, 8'h00);
            chk("rst_ack", {6'd0, ack1, ack0}, 8'h00);
        end

        // First grant after reset.
        next_cyc();
        reset = 1'b0;
        mid_cyc();
        chk("first_lat", {6'd0, gnt1, gnt0}, 8'h00);
        next_cyc();
        mem_ready = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        push_ack(1'b0);
        mid_cyc();
        chk("first_gnt", {6'd0, gnt1, gnt0}, 8'h01);
        chk("first_sel", {7'd0, sel}, 8'h00);
`else
        push_ack(1'b1);
        mid_cyc();
        chk("first_gnt", {6'd0, gnt1, gnt0}, 8'h02);
        chk("first_sel", {7'd0, sel}, 8'h01);
`endif
        chk("first_mv", {7'd0, mem_valid}, 8'h01);
        next_cyc();
        req0 = 1'b0;
        req1 = 1'b0;
        mem_ready = 1'b0;
        mid_cyc();
        chk("first_mv_drop", {7'd0, mem_valid}, 8'h00);
        next_cyc();
        mem_ready = 1'b1;
        mid_cyc();
        chk("idle_gnt", {6'd0, gnt1, gnt0}, 8'h00);
        chk("idle_mv",  {7'd0, mem_valid}, 8'h00);
        chk("idle_ack", {6'd0, ack1, ack0}, 8'h00);
`ifdef ARB_ROUND_ROBIN_EN
        chk("idle_sel", {7'd0, sel}, 8'h00);
`else
        chk("idle_sel", {7'd0, sel}, 8'h01);
`endif

        // Single beat: req0 at cycle 2, ready at 4, req0 drops at 5.
        next_cyc();
        mem_ready = 1'b0;
        req0 = 1'b1;
        mid_cyc();
        chk("sb_c2_gnt", {6'd0, gnt1, gnt0}, 8'h00);
        next_cyc();
        mid_cyc();
        chk("sb_c3_gnt", {6'd0, gnt1, gnt0}, 8'h01);
        chk("sb_c3_sel", {7'd0, sel}, 8'h00);
        chk("sb_c3_mv",  {7'd0, mem_valid}, 8'h01);
        chk("sb_c3_ack", {6'd0, ack1, ack0}, 8'h00);
        next_cyc();
        mem_ready = 1'b1;
        push_ack(1'b0);
        mid_cyc();
        chk("sb_c4_ack", {6'd0, ack1, ack0}, 8'h01);
        next_cyc();
        req0 = 1'b0;
        mem_ready = 1'b0;
        mid_cyc();
        chk("sb_c5_gnt", {6'd0, gnt1, gnt0}, 8'h01);
        chk("sb_c5_ack", {6'd0, ack1, ack0}, 8'h00);
        next_cyc();
        mid_cyc();
        chk("sb_c6_gnt", {6'd0, gnt1, gnt0}, 8'h00);

`ifdef ARB_ROUND_ROBIN_EN
        // Forced release: 4 beats of req0, IDLE, 4 beats of req1, IDLE, back to req0.
        next_cyc();
        req0 = 1'b1;
        mem_ready = 1'b1;
        mid_cyc();
        chk("fr_start", {6'd0, gnt1, gnt0}, 8'h00);
        for (int i = 1; i <= 11; i++) begin
            next_cyc();
            if (i == 1) req1 = 1'b1;
            if (i <= 4 || i == 11)     eg = 2'b01;
            else if (i >= 6 && i <= 9) eg = 2'b10;
            else                       eg = 2'b00;
            es = (i >= 6 && i <= 10);
            if (eg != 2'b00) push_ack(eg[1]);
            mid_cyc();
            chk("fr_gnt", {6'd0, gnt1, gnt0}, {6'd0, eg});
            chk("fr_ack", {6'd0, ack1, ack0}, {6'd0, eg});
            chk("fr_sel", {7'd0, sel}, {7'd0, es});
            chk("fr_mv",  {7'd0, mem_valid}, {7'd0, (eg != 2'b00)});
        end
        next_cyc();
        req0 = 1'b0;
        req1 = 1'b0;
        mem_ready = 1'b0;
        mid_cyc();
        next_cyc();
        mid_cyc();
        chk("fr_end", {6'd0, gnt1, gnt0}, 8'h00);
`else
        // Fixed priority: requester 1 keeps the port while both request.
        next_cyc();
        req0 = 1'b1;
        req1 = 1'b1;
        mem_ready = 1'b1;
        mid_cyc();
        chk("fp_start", {6'd0, gnt1, gnt0}, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            next_cyc();
            push_ack(1'b1);
            mid_cyc();
            chk("fp_gnt", {6'd0, gnt1, gnt0}, 8'h02);
            chk("fp_ack", {6'd0, ack1, ack0}, 8'h02);
        end
        next_cyc();
        req0 = 1'b0;
        req1 = 1'b0;
        mem_ready = 1'b0;
        mid_cyc();
        next_cyc();
        mid_cyc();
        chk("fp_end", {6'd0, gnt1, gnt0}, 8'h00);
`endif

        // No competitor: 10 consecutive beats, grant never drops.
        next_cyc();
        req0 = 1'b1;
        mem_ready = 1'b1;
        mid_cyc();
        chk("nc_start", {6'd0, gnt1, gnt0}, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            next_cyc();
            push_ack(1'b0);
            mid_cyc();
            chk("nc_gnt", {6'd0, gnt1, gnt0}, 8'h01);
            chk("nc_ack", {6'd0, ack1, ack0}, 8'h01);
        end
        next_cyc();
        req0 = 1'b0;
        mem_ready = 1'b0;
        mid_cyc();
        next_cyc();
        mid_cyc();
        chk("nc_end", {6'd0, gnt1, gnt0}, 8'h00);

        // Reset mid-beat: stalled beat of requester 1 is abandoned.
        next_cyc();
        req1 = 1'b1;
        mid_cyc();
        next_cyc();
        mid_cyc();
        chk("rm_gnt", {6'd0, gnt1, gnt0}, 8'h02);
        chk("rm_sel", {7'd0, sel}, 8'h01);
        chk("rm_mv",  {7'd0, mem_valid}, 8'h01);
        next_cyc();
        reset = 1'b1;
        mid_cyc();
        chk("rm_rst_ack", {6'd0, ack1, ack0}, 8'h00);
        chk("rm_rst_mv",  {7'd0, mem_valid}, 8'h00);
        next_cyc();
        reset = 1'b0;
        mid_cyc();
        chk("rm_after_gnt", {6'd0, gnt1, gnt0}, 8'h00);
        chk("rm_after_sel", {7'd0, sel}, 8'h00);
        chk("rm_after_mv",  {7'd0, mem_valid}, 8'h00);
        next_cyc();
        mem_ready = 1'b1;
        push_ack(1'b1);
        mid_cyc();
        chk("rm_retry_gnt", {6'd0, gnt1, gnt0}, 8'h02);
        chk("rm_retry_ack", {6'd0, ack1, ack0}, 8'h02);
        next_cyc();
        req1 = 1'b0;
        mem_ready = 1'b0;
        next_cyc();
        mid_cyc();
        chk("rm_end", {6'd0, gnt1, gnt0}, 8'h00);

        chk("sb_drain", 8'(exp_ack_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
